// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_t    : EX-stage operation encodings (6/7 are no-ops)
//   md_state_t : control FSM states
//   md_mode_t  : datapath mode for a single iteration step
//   abs_w()    : conditional two's-complement negate over a wide bus;
//                callers zero-extend into it and truncate back to their width
package muldiv_pkg;

  // Widest bus abs_w() handles: covers the 2*WIDTH product for WIDTH <= 64.
  localparam int MD_MAX_W = 128;

  typedef enum logic [2:0] {
    MD_MULTU = 3'd0,
    MD_MULT  = 3'd1,
    MD_DIVU  = 3'd2,
    MD_DIV   = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  typedef enum logic {
    MD_MODE_MUL = 1'b0,
    MD_MODE_DIV = 1'b1
  } md_mode_t;

  // Magnitude of v when neg marks it as negative. Used both to strip
  // operand signs and to re-apply result signs. Negation of a zero-extended
  // value truncates to the correct narrow two's complement.
  function automatic logic [MD_MAX_W-1:0] abs_w(input logic [MD_MAX_W-1:0] v,
                                                input logic                neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   acc      in  2*WIDTH  accumulator {upper, lower}
//   operand  in  WIDTH    multiplicand (mul) or divisor magnitude (div)
//   mode     in  1        MD_MODE_MUL: shift-add; MD_MODE_DIV: restoring trial-subtract
//   acc_nxt  out 2*WIDTH  accumulator after this iteration
// Mul: lower half starts as the multiplier and is shifted out LSB first while
//      the product builds from the top. Div: lower half starts as the dividend
//      and is shifted out MSB first while quotient bits shift in at the bottom.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  md_mode_t           mode,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Carry out of the add becomes the new MSB after the right shift.
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
             {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    // Partial remainder after pulling in the next dividend bit; it can need
    // WIDTH+1 bits, so the borrow is the MSB of the WIDTH+1 difference.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, operand};
    if (mode == MD_MODE_DIV) begin
      if (!diff[WIDTH])
        acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
//   clk, rst        clock / synchronous active-high reset
//   start, op       EX-stage op valid and encoding (md_op_t), sampled in IDLE
//   a, b            rs / rt operands
//   rd_req          EX holds MFHI/MFLO this cycle
//   flush           squash the in-flight op (beats start and the FIX write)
//   busy            op in progress (RUN or FIX)
//   done            one-cycle pulse after HI/LO were written by mult/div
//   stall_req       busy & (start | rd_req)
//   hi, lo          architectural HI/LO
// Timing: start at edge k -> RUN for WIDTH cycles -> FIX for 1 cycle ->
// HI/LO written at the FIX->IDLE edge, done high in cycle k+WIDTH+2.
// WIDTH must be even, >= 4 and <= 64.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            DW   = 2 * WIDTH;
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    acc_nxt;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] a_raw;
  logic             sign_a, sign_b;
  md_op_t           op_q;

  // Issue-side decode on the raw inputs.
  logic             op_md, op_signed;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  // Latched-op decode and FIX results.
  logic             is_div_q, is_signed_q;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_md     = !op[2];
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign mag_a_in  = WIDTH'(abs_w(MD_MAX_W'(a), op_signed & a[WIDTH-1]));
  assign mag_b_in  = WIDTH'(abs_w(MD_MAX_W'(b), op_signed & b[WIDTH-1]));

  assign is_div_q    = (op_q == MD_DIVU) || (op_q == MD_DIV);
  assign is_signed_q = (op_q == MD_MULT) || (op_q == MD_DIV);

  assign busy      = (state != MD_IDLE);
  assign stall_req = busy & (start | rd_req);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .operand (mag_b),
    .mode    (is_div_q ? MD_MODE_DIV : MD_MODE_MUL),
    .acc_nxt (acc_nxt)
  );

  // Sign correction; only consumed in FIX.
  always_comb begin
    prod   = DW'(abs_w(MD_MAX_W'(acc), is_signed_q & (sign_a ^ sign_b)));
    quo    = WIDTH'(abs_w(MD_MAX_W'(acc[WIDTH-1:0]), is_signed_q & (sign_a ^ sign_b)));
    rem    = WIDTH'(abs_w(MD_MAX_W'(acc[DW-1:WIDTH]), is_signed_q & sign_a));
    res_hi = prod[DW-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (mag_b == '0) begin
        // Divide by zero: defined result rather than whatever the loop left.
        res_lo = '1;
        res_hi = a_raw;
      end else begin
        // MIN / -1 falls out naturally: |MIN| = MIN, quotient sign positive.
        res_lo = quo;
        res_hi = rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      a_raw  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_q   <= MD_MULTU;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start && !flush) begin
            if (op_md) begin
              state  <= MD_RUN;
              cnt    <= '0;
              acc    <= {{WIDTH{1'b0}}, mag_a_in};
              mag_b  <= mag_b_in;
              a_raw  <= a;
              sign_a <= op_signed & a[WIDTH-1];
              sign_b <= op_signed & b[WIDTH-1];
              op_q   <= md_op_t'(op);
            end else if (op == MD_MTHI) begin
              hi <= a;
            end else if (op == MD_MTLO) begin
              lo <= a;
            end
          end
        end
        MD_RUN: begin
          if (flush) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_nxt;
            if (cnt == LAST) state <= MD_FIX;
            else             cnt   <= cnt + 1'b1;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, rd_req, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, stall_req;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .flush(flush), .busy(busy), .done(done),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  task automatic ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] eh, output logic [31:0] el);
    longint p;
    int     sx, sy;
    sx = x;
    sy = y;
    eh = '0;
    el = '0;
    case (o)
      3'd0: begin
        p  = longint'({32'd0, x}) * longint'({32'd0, y});
        eh = p[63:32]; el = p[31:0];
      end
      3'd1: begin
        p  = longint'(sx) * longint'(sy);
        eh = p[63:32]; el = p[31:0];
      end
      3'd2: begin
        if (y == 0) begin el = '1; eh = x; end
        else begin el = x / y; eh = x % y; end
      end
      default: begin
        if (y == 0) begin el = '1; eh = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin el = x; eh = 0; end
        else begin el = sx / sy; eh = sx % sy; end
      end
    endcase
  endtask

  // Issue one mult/div from IDLE and check latency, hold, pulse and result.
  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el, h0, l0;
    int nb, guard;
    bit held;
    ref_md(o, x, y, eh, el);
    h0 = hi; l0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands must have been latched
    nb = 0; guard = 0; held = 1'b1;
    while (busy && guard < 100) begin
      if (hi !== h0 || lo !== l0 || done !== 1'b0) held = 1'b0;
      nb++; guard++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(W + 1));
    chk({tag, "_hold"}, 64'(held), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] h0, l0, eh, el;
    int guard;
    bit quiet;

    rst = 1'b1; start = 1'b0; rd_req = 1'b0; flush = 1'b0;
    op = '0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rd_req = 1'b1; #1;
    chk("idle_no_stall", 64'(stall_req), 64'd0);
    rd_req = 1'b0;

    // Directed arithmetic corners.
    do_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max_lo_k", 64'(lo), 64'h1);
    do_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div_neg_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    do_op("div_min", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_zero", 3'd2, 32'd7, 32'd0);
    do_op("div_zero_neg", 3'd3, 32'hFFFF_FF00, 32'd0);

    // Flush in RUN cycle 10.
    h0 = hi; l0 = lo;
    op = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    chk("flush_quiet", 64'(quiet), 64'd1);
    chk("flush_hi", 64'(hi), 64'(h0));
    chk("flush_lo", 64'(lo), 64'(l0));

    // Flush landing on the FIX cycle beats the write.
    op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    tick(); start = 1'b0;
    repeat (W) tick();
    chk("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("fixflush_busy", 64'(busy), 64'd0);
    chk("fixflush_done", 64'(done), 64'd0);
    chk("fixflush_hi", 64'(hi), 64'(h0));
    chk("fixflush_lo", 64'(lo), 64'(l0));

    // Stall handshake: second op presented while busy is ignored, then reissued.
    ref_md(3'd0, 32'd12345, 32'd678, eh, el);
    op = 3'd0; a = 32'd12345; b = 32'd678; start = 1'b1;
    tick();
    op = 3'd3; a = 32'hFFFF_0000; b = 32'd7; rd_req = 1'b1; #1;
    chk("stall_start_rd", 64'(stall_req), 64'd1);
    repeat (3) tick();
    chk("stall_held", 64'(stall_req), 64'd1);
    start = 1'b0; rd_req = 1'b0; #1;
    chk("stall_clear", 64'(stall_req), 64'd0);
    rd_req = 1'b1; #1;
    chk("stall_rd_only", 64'(stall_req), 64'd1);
    rd_req = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin guard++; tick(); end
    chk("stall_first_hi", 64'(hi), 64'(eh));
    chk("stall_first_lo", 64'(lo), 64'(el));
    tick();
    chk("stall_no_second", 64'(busy), 64'd0);
    do_op("reissue", 3'd3, 32'hFFFF_0000, 32'd7);

    // Reset mid-operation.
    op = 3'd1; a = 32'd77; b = 32'd88; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);

    // MTHI / MTLO, start+flush, no-op encodings.
    op = 3'd4; a = 32'h1234; start = 1'b1;
    tick(); start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    op = 3'd5; a = 32'hCAFE_F00D; start = 1'b1;
    tick(); start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    op = 3'd5; a = 32'h5555_AAAA; start = 1'b1; flush = 1'b1;
    tick(); start = 1'b0; flush = 1'b0;
    chk("mtlo_flush_lo", 64'(lo), 64'hCAFE_F00D);
    op = 3'd2; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
    tick(); start = 1'b0; flush = 1'b0;
    chk("div_flush_busy", 64'(busy), 64'd0);
    op = 3'd7; a = 32'hDEAD_BEEF; start = 1'b1;
    tick(); start = 1'b0;
    chk("noop_busy", 64'(busy), 64'd0);
    chk("noop_hi", 64'(hi), 64'h1234);
    chk("noop_lo", 64'(lo), 64'hCAFE_F00D);

    // Random mult/div against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i == 0) ra = 32'h8000_0000;
      do_op($sformatf("rnd%0d", i), ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
